// File: rtl/arith_core_checker.sv
// ---------------------------------------------------------------------------
// arith_core_checker
//   Sequential consumer/checker for the 5-operand arithmetic core.
//   A vector accepted on in_valid/in_ready is registered onto core_*. It is
//   held there for SETTLE_CYC cycles, and then core_y is sampled. The expected
//   result is rebuilt with a single shared shift-add multiplier that handles
//   four products, one multiplier bit per cycle. The sampled value, the
//   expected value and a mismatch flag are returned on out_valid/out_ready.
//   A saturating counter tracks mismatching records.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake
//   in_a..in_e, in_mode      operand vector and function select
//   core_a..core_e,core_mode registered operands driven to the core
//   core_y                   combinational core result
//   out_valid/out_ready      result handshake
//   out_y, out_exp           sampled and expected result
//   out_mismatch             out_y != out_exp
//   err_count                saturating mismatch counter
// ---------------------------------------------------------------------------
module arith_core_checker #(
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic [DATA_W-1:0]     in_c,
    input  logic [DATA_W-1:0]     in_d,
    input  logic [DATA_W-1:0]     in_e,
    input  logic [1:0]            in_mode,
    output logic [DATA_W-1:0]     core_a,
    output logic [DATA_W-1:0]     core_b,
    output logic [DATA_W-1:0]     core_c,
    output logic [DATA_W-1:0]     core_d,
    output logic [DATA_W-1:0]     core_e,
    output logic [1:0]            core_mode,
    input  logic [2*DATA_W-1:0]   core_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_y,
    output logic [2*DATA_W-1:0]   out_exp,
    output logic                  out_mismatch,
    output logic [15:0]           err_count
);

    localparam int RW  = 2 * DATA_W;
    localparam int SW  = (RW > 1) ? $clog2(RW) : 1;
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, DRIVE, CALC, COMB, DONE} state_t;

    state_t          state;
    logic [SCW-1:0]  settle_cnt;
    logic [1:0]      prod_idx;
    logic [SW-1:0]   step;
    logic [RW-1:0]   prod [4];

    logic [RW-1:0]   za, zb, zc, zd, ze;
    logic [RW-1:0]   mcand, mplier, partial;
    logic [RW-1:0]   m1, m2, m3, m4, exp_next;
    logic            mismatch_next;

    // The core_* registers hold the accepted vector for the whole check, so
    // the multiplier reads its operands from them instead of keeping copies.
    assign za = RW'(core_a);
    assign zb = RW'(core_b);
    assign zc = RW'(core_c);
    assign zd = RW'(core_d);
    assign ze = RW'(core_e);

    // Operand selection for the product being built. A partial term is the
    // multiplicand shifted to the current multiplier bit, or zero if the bit is clear.
    always_comb begin
        mcand  = '0;
        mplier = '0;
        case (prod_idx)
            2'd0: begin mcand = za + zb;         mplier = zc + zd; end
            2'd1: begin mcand = za;              mplier = zc;      end
            2'd2: begin mcand = zb;              mplier = zd;      end
            default: begin mcand = (za ^ zb) + zd; mplier = ze;    end
        endcase
        partial = mplier[step] ? (mcand << step) : '0;
    end

    // Combine the finished products. This is only consumed in COMB.
    always_comb begin
        m1 = prod[0];
        m2 = prod[1] + prod[2];
        m3 = prod[3];
        m4 = (m1 + m2) ^ (m3 >> 2);
        case (core_mode)
            2'd0:    exp_next = m1;
            2'd1:    exp_next = m2;
            2'd2:    exp_next = m3;
            default: exp_next = m4;
        endcase
        mismatch_next = (out_y != exp_next);
    end

    // Control FSM and datapath registers. Reset overrides every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            core_a       <= '0;
            core_b       <= '0;
            core_c       <= '0;
            core_d       <= '0;
            core_e       <= '0;
            core_mode    <= '0;
            out_y        <= '0;
            out_exp      <= '0;
            out_mismatch <= 1'b0;
            err_count    <= '0;
            settle_cnt   <= '0;
            prod_idx     <= '0;
            step         <= '0;
            for (int i = 0; i < 4; i++) prod[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        core_a     <= in_a;
                        core_b     <= in_b;
                        core_c     <= in_c;
                        core_d     <= in_d;
                        core_e     <= in_e;
                        core_mode  <= in_mode;
                        settle_cnt <= '0;
                        in_ready   <= 1'b0;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                        out_y    <= core_y;
                        prod_idx <= '0;
                        step     <= '0;
                        state    <= CALC;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CALC: begin
                    // The accumulator restarts from zero on the first step of each product.
                    prod[prod_idx] <= ((step == '0) ? '0 : prod[prod_idx]) + partial;
                    if (step == SW'(RW - 1)) begin
                        step     <= '0;
                        prod_idx <= prod_idx + 1'b1;
                        if (prod_idx == 2'd3) state <= COMB;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                COMB: begin
                    out_exp      <= exp_next;
                    out_mismatch <= mismatch_next;
                    if (mismatch_next && (err_count != 16'hFFFF))
                        err_count <= err_count + 16'd1;
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    // in_ready rises together with the return to IDLE, so the
                    // earliest new accept is one cycle after the release.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_core_checker.sv
// ---------------------------------------------------------------------------
// tb_arith_core_checker
//   Self-checking bench for arith_core_checker. The core sitting on the
//   other side is modelled by a behavioural function. That function can be
//   corrupted on purpose through the flip input. Expected results come from
//   a table of hand constants and from the same behavioural model applied to
//   random vectors.
// ---------------------------------------------------------------------------
module tb_arith_core_checker;

    localparam int DATA_W = 8;
    localparam int S      = 1;
    localparam int LAT    = S + 65;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b, in_c, in_d, in_e;
    logic [1:0]  in_mode;
    logic [7:0]  core_a, core_b, core_c, core_d, core_e;
    logic [1:0]  core_mode;
    logic [15:0] core_y;
    logic        out_valid, out_ready;
    logic [15:0] out_y, out_exp;
    logic        out_mismatch;
    logic [15:0] err_count;
    logic        flip;

    int checks = 0;
    int errors = 0;
    int err_model = 0;

    always #5 clk = ~clk;

    // Reference arithmetic written directly from the defining equations.
    // It uses plain integers masked to 16 bits.
    function automatic logic [15:0] ref_model(input int a, input int b, input int c,
                                              input int d, input int e, input int mode);
        int p1, p2, p3, p4, m1, m2, m3, m4;
        p1 = ((a + b) * (c + d)) & 'hFFFF;
        p2 = (a * c) & 'hFFFF;
        p3 = (b * d) & 'hFFFF;
        p4 = (((a ^ b) + d) * e) & 'hFFFF;
        m1 = p1;
        m2 = (p2 + p3) & 'hFFFF;
        m3 = p4;
        m4 = ((m1 + m2) & 'hFFFF) ^ (m3 >> 2);
        case (mode)
            0:       return 16'(m1);
            1:       return 16'(m2);
            2:       return 16'(m3);
            default: return 16'(m4);
        endcase
    endfunction

    // Behavioural arithmetic core. Setting flip corrupts the LSB.
    assign core_y = ref_model(int'(core_a), int'(core_b), int'(core_c), int'(core_d),
                              int'(core_e), int'(core_mode)) ^ {15'd0, flip};

    arith_core_checker #(.DATA_W(DATA_W), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .in_mode(in_mode),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .core_e(core_e), .core_mode(core_mode), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_exp(out_exp), .out_mismatch(out_mismatch),
        .err_count(err_count)
    );

    typedef struct {
        logic [7:0]  a, b, c, d, e;
        logic [1:0]  mode;
        logic        flip;
        logic [15:0] exp_y;
        logic        exp_mm;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one vector for a single accept edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input logic [7:0] d, input logic [7:0] e, input logic [1:0] m,
                                 input logic f);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        in_a = a; in_b = b; in_c = c; in_d = d; in_e = e; in_mode = m;
        flip = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("in_ready_after_accept", in_ready, 0);
    endtask

    // Counts edges after the accept edge until out_valid appears.
    task automatic waitResult(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 300);
        if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
    endtask

    task automatic drainResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("out_valid_drop", out_valid, 0);
        checkOutput("in_ready_return", in_ready, 1);
    endtask

    task automatic checkRecord(input string tag, input logic [15:0] exp_y, input logic mm,
                               input logic f, input int lat);
        checkOutput({tag, "_latency"}, lat, LAT);
        checkOutput({tag, "_out_exp"}, out_exp, exp_y);
        checkOutput({tag, "_out_y"}, out_y, exp_y ^ {15'd0, f});
        checkOutput({tag, "_mismatch"}, out_mismatch, mm);
        if (mm && err_model != 'hFFFF) err_model++;
        checkOutput({tag, "_err_count"}, err_count, err_model);
    endtask

    task automatic runVec(input string tag, input vec_t v);
        int lat;
        applyStimulus(v.a, v.b, v.c, v.d, v.e, v.mode, v.flip);
        waitResult(lat);
        checkRecord(tag, v.exp_y, v.exp_mm, v.flip, lat);
        drainResult();
    endtask

    vec_t tbl[7];
    vec_t v;
    logic [15:0] held_y, held_exp;
    logic        held_mm;
    int          lat;

    initial begin
        tbl[0] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd0, 1'b0, 16'h0015, 1'b0};
        tbl[1] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd1, 1'b0, 16'h000B, 1'b0};
        tbl[2] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd2, 1'b0, 16'h0023, 1'b0};
        tbl[3] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd3, 1'b0, 16'h0028, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 2'd0, 1'b0, 16'hF804, 1'b0};
        tbl[5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd0, 1'b1, 16'h0015, 1'b1};
        tbl[6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'd3, 1'b0, 16'h0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flip = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0; in_mode = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_out_exp", out_exp, 0);
        checkOutput("reset_out_y", out_y, 0);
        checkOutput("reset_core_a", core_a, 0);

        // Table vectors: the known sums, the wrap case, and an injected mismatch
        // followed by clean vectors.
        for (int i = 0; i < 7; i++) runVec($sformatf("tbl%0d", i), tbl[i]);

        // Random vectors against the behavioural model.
        for (int i = 0; i < 20; i++) begin
            v.a = 8'($urandom); v.b = 8'($urandom); v.c = 8'($urandom);
            v.d = 8'($urandom); v.e = 8'($urandom); v.mode = 2'($urandom);
            v.flip = ($urandom_range(0, 3) == 0);
            v.exp_y = ref_model(int'(v.a), int'(v.b), int'(v.c), int'(v.d), int'(v.e), int'(v.mode));
            v.exp_mm = v.flip;
            runVec($sformatf("rnd%0d", i), v);
        end

        // Back-pressure in DONE with a competing vector on the input.
        applyStimulus(8'd9, 8'd7, 8'd5, 8'd3, 8'd1, 2'd3, 1'b0);
        waitResult(lat);
        checkRecord("bp", ref_model(9, 7, 5, 3, 1, 3), 1'b0, 1'b0, lat);
        held_y = out_y; held_exp = out_exp; held_mm = out_mismatch;
        in_a = 8'd20; in_b = 8'd30; in_c = 8'd40; in_d = 8'd50; in_e = 8'd60; in_mode = 2'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_out_y", out_y, held_y);
            checkOutput("bp_out_exp", out_exp, held_exp);
            checkOutput("bp_mismatch", out_mismatch, held_mm);
            checkOutput("bp_core_a", core_a, 9);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_ready", in_ready, 1);
        checkOutput("bp_release_core_a", core_a, 9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_accept_ready", in_ready, 0);
        checkOutput("bp_accept_core_a", core_a, 20);
        waitResult(lat);
        checkRecord("bp2", ref_model(20, 30, 40, 50, 60, 1), 1'b0, 1'b0, lat);
        drainResult();

        // Reset in the middle of CALC, with a nonzero error count.
        runVec("pre_rst", tbl[5]);
        applyStimulus(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 2'd0, 1'b0);
        repeat (S + 29) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        err_model = 0;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_err_count", err_count, 0);
        checkOutput("midrst_core_a", core_a, 0);
        checkOutput("midrst_out_y", out_y, 0);
        runVec("post_rst", tbl[3]);

        // Saturation: preload the counter near the top, then push two mismatches.
        force dut.err_count = 16'hFFFE;
        @(negedge clk);
        release dut.err_count;
        err_model = 'hFFFE;
        runVec("sat1", tbl[5]);
        runVec("sat2", tbl[5]);
        checkOutput("sat_hold", err_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
